// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, with a
// registered inter-digit carry and a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int D  = WIDTH / DIGIT;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ripple slice result packed as {carry out of MSB, carry into MSB, sum digit}.
  function automatic logic [DIGIT+1:0] slice_add(input logic [DIGIT-1:0] a,
                                                 input logic [DIGIT-1:0] b,
                                                 input logic             cin);
    logic             c;
    logic             c_msb;
    logic [DIGIT-1:0] s;
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, c_msb, s};
  endfunction

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     res_q;
  logic                 carry_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     s_q;
  logic                 cout_q;
  logic                 ovf_q;

  logic [DIGIT+1:0]     slice_d;
  logic [WIDTH+DIGIT-1:0] res_ext_d;
  logic [WIDTH-1:0]     res_d;
  logic                 slice_cout_d;
  logic                 msb_cin_d;

  // Current digit through the slice; new sum digit enters the result from the top.
  always_comb begin
    slice_d      = slice_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    slice_cout_d = slice_d[DIGIT+1];
    msb_cin_d    = slice_d[DIGIT];
    res_ext_d    = {slice_d[DIGIT-1:0], res_q};
    res_d        = res_ext_d[WIDTH+DIGIT-1:DIGIT];
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub ? 1'b1 : i_carry_in;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= slice_cout_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            s_q     <= res_d;
            cout_q  <= slice_cout_d;
            ovf_q   <= msb_cin_d ^ slice_cout_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_s         = s_q;
  assign o_carry_out = cout_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: DIGIT=1 and DIGIT=4 instances, directed
// vectors with hand-computed results, latency/busy checks in the monitors.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic       sub = 1'b0, cin = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;

  logic       busy8, done8, c8, v8;
  logic [7:0] s8;
  logic       busy4, done4, c4, v4;
  logic [7:0] s4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bcnt8 = 0;
  int bcnt4 = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         t;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .i_clk(clk), .i_reset(rst), .i_start(start8), .i_sub(sub), .i_a(a), .i_b(b),
    .i_carry_in(cin), .o_busy(busy8), .o_done(done8), .o_s(s8),
    .o_carry_out(c8), .o_overflow(v8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .i_clk(clk), .i_reset(rst), .i_start(start4), .i_sub(sub), .i_a(a), .i_b(b),
    .i_carry_in(cin), .o_busy(busy4), .o_done(done4), .o_s(s4),
    .o_carry_out(c4), .o_overflow(v4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // DIGIT=1 monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt8 = 0;
    end else begin
      if (busy8) bcnt8++;
      if (done8) begin
        if (q8.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done8: got done with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = q8.pop_front();
          chk("s8", 32'(s8), 32'(e.s));
          chk("cout8", 32'(c8), 32'(e.c));
          chk("ovf8", 32'(v8), 32'(e.v));
          chk("lat8", 32'(cyc), 32'(e.t));
          chk("busy8_len", 32'(bcnt8), 32'd8);
        end
        bcnt8 = 0;
      end
    end
  end

  // DIGIT=4 monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt4 = 0;
    end else begin
      if (busy4) bcnt4++;
      if (done4) begin
        if (q4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done4: got done with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = q4.pop_front();
          chk("s4", 32'(s4), 32'(e.s));
          chk("cout4", 32'(c4), 32'(e.c));
          chk("ovf4", 32'(v4), 32'(e.v));
          chk("lat4", 32'(cyc), 32'(e.t));
          chk("busy4_len", 32'(bcnt4), 32'd2);
        end
        bcnt4 = 0;
      end
    end
  end

  task automatic push8(input logic [7:0] es, input logic ec, input logic ev);
    exp_t e;
    e.s = es; e.c = ec; e.v = ev; e.t = cyc + 1 + 8;
    q8.push_back(e);
  endtask

  task automatic issue(input bit w4, input logic [7:0] ia, input logic [7:0] ib,
                       input logic isub, input logic icin,
                       input logic [7:0] es, input logic ec, input logic ev);
    exp_t e;
    @(posedge clk); #1;
    a = ia; b = ib; sub = isub; cin = icin;
    if (w4) begin
      start4 = 1'b1;
      e.s = es; e.c = ec; e.v = ev; e.t = cyc + 1 + 2;
      q4.push_back(e);
    end else begin
      start8 = 1'b1;
      push8(es, ec, ev);
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q8.size() != 0 || q4.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d/%0d pending results expected 0", q8.size(), q4.size());
      q8.delete();
      q4.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_s8", 32'(s8), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    rst = 1'b0;

    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_done();
    issue(1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    wait_done();
    issue(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    wait_done();
    issue(1'b1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_done();

    // start held through RUN with junk operands, then a new pair in the DONE cycle
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start8 = 1'b1;
    push8(8'h46, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      a = 8'(k * 37 + 200); b = 8'(k * 11 + 99); sub = k[0]; cin = 1'b1;
      @(posedge clk); #1;
    end
    a = 8'h70; b = 8'h10; sub = 1'b1; cin = 1'b0;
    push8(8'h60, 1'b1, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done();

    // reset in the third cycle of an operation
    issue(1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    chk("hold_s8", 32'(s8), 32'h60);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy8", 32'(busy8), 32'd0);
    chk("mid_rst_done8", 32'(done8), 32'd0);
    chk("mid_rst_s8", 32'(s8), 32'd0);
    chk("mid_rst_cout8", 32'(c8), 32'd0);
    chk("mid_rst_ovf8", 32'(v8), 32'd0);
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    issue(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, using a single DIGIT-bit ripple slice built from full-adder cells and a registered carry between digits. It trades latency for area in datapaths that do not need single-cycle addition, and adds a start/busy/done handshake, subtraction mode and signed-overflow detection.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_start  input  1  request; accepted only when o_busy = 0.
- i_sub  input  1  0 = add, 1 = subtract (captured with operands).
- i_a  input  WIDTH  operand A (captured on accept).
- i_b  input  WIDTH  operand B (captured on accept).
- i_carry_in  input  1  carry seed for add mode; ignored when i_sub = 1.
- o_busy  output  1  high while an operation is in progress.
- o_done  output  1  one-cycle pulse, result valid.
- o_s  output  WIDTH  result.
- o_carry_out  output  1  carry out of MSB (add); in subtract mode 1 = no borrow.
- o_overflow  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. D = WIDTH/DIGIT digit steps.
- IDLE: o_busy = 0. If i_start = 1 at an edge, capture i_a, effective B (i_b, or ~i_b when i_sub), and carry seed (i_carry_in, or 1 when i_sub). Clear the digit counter and go to RUN.
- RUN: o_busy = 1. Each cycle, add digit k of A, B and the carry register through the DIGIT-bit slice. Store the sum digit into the result shift register and the slice carry into the carry register, then increment k. After digit D-1 go to DONE.
- Overflow = carry into MSB XOR carry out of MSB, taken from the final digit's slice.
- On entering DONE, copy the result register, final carry and overflow to o_s / o_carry_out / o_overflow. These outputs change at no other time and hold until the next completion or reset.
- DONE: o_done = 1, o_busy = 0, lasts one cycle. An i_start in DONE is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- i_start while o_busy = 1 is ignored; operands are not re-captured.
- Input changes after capture do not affect the running operation.

## Timing
- Reset (asynchronous assert, any state): state IDLE, o_busy = 0, o_done = 0, o_s = 0, o_carry_out = 0, o_overflow = 0, internal registers cleared. An operation in progress is aborted and no o_done is produced.
- Accept at edge 0 → o_busy high after edges 0..D-1 → after edge D: o_done = 1 and results valid → after edge D+1: o_done = 0.
- Latency from accept edge to o_done high is D edges. Throughput is one operation per D+1 cycles in back-to-back use.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=1, add: A=0x5A, B=0x3C, cin=0 → o_s=0x96, o_carry_out=0, o_overflow=1. o_done is high exactly 8 edges after accept, for 1 cycle.
- WIDTH=8, DIGIT=1, add: A=0xFF, B=0x01, cin=0 → o_s=0x00, o_carry_out=1, o_overflow=0. With cin=1 and A=0x7F, B=0x00 → o_s=0x80, o_overflow=1.
- WIDTH=8, DIGIT=1, sub: A=0x10, B=0x20 → o_s=0xF0, o_carry_out=0, o_overflow=0. Also A=0x80, B=0x01 → o_s=0x7F, o_carry_out=1, o_overflow=1.
- WIDTH=8, DIGIT=4: A=0xA5, B=0x5B, add → o_s=0x00, o_carry_out=1. o_busy high for exactly 2 cycles, o_done 2 edges after accept.
- Handshake: i_start held high with changing operands during RUN → ignored, result matches the captured pair. i_start in the DONE cycle with new operands → accepted, second result correct, no idle gap.
- Reset mid-operation: assert i_reset in cycle 3 of an 8-cycle add → o_busy, o_done and all outputs 0 immediately. After release, no spurious o_done, and a new operation completes correctly.
